hue_frame_ctrl: RTL and testbench
=================================

Name: hue_frame_ctrl

Overview:
- Frame-level sequencer that gates the camera RGB pixel stream into the 6-stage RGB-to-hue pipeline.
- Arms on a start command and aligns to start-of-frame. Counts pixels, marks the last pixel with done, then waits for the pipeline to drain.
- Reports frame completion, frame count and errors. Sits between the camera capture front end and the hue pipeline.

Parameters:
- NUM_PIXELS, 307200: pixels per frame (640x480).
- CNT_W, 19: pixel counter width, at least ceil(log2(NUM_PIXELS+1)).
- DRAIN_TIMEOUT, 16: maximum cycles in DRAIN waiting for ret_done; must exceed the pipeline latency of 6.
- FCNT_W, 16: frame counter width.

Ports:
- clock  in  1  sole clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; arms capture.
- abort  in  1  one-cycle pulse; returns to IDLE.
- continuous  in  1  1: re-arm after each frame; sampled in DONE.
- cam_valid  in  1  camera pixel valid.
- cam_sof  in  1  start-of-frame; qualified by cam_valid.
- cam_red, cam_green, cam_blue  in  8 each  camera pixel.
- cam_visual  in  1  sideband passed through.
- pipe_valid  out  1  pixel valid to the hue pipeline.
- pipe_red, pipe_green, pipe_blue  out  8 each  pixel to the pipeline.
- pipe_visual  out  1  sideband to the pipeline.
- pipe_done  out  1  high together with the last pixel of the frame.
- ret_done  in  1  done returned from the pipeline output.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse per completed frame.
- frame_count  out  FCNT_W  completed frames; wraps.
- pixel_count  out  CNT_W  pixels forwarded in the current frame.
- err_short  out  1  sticky; cam_sof seen mid-frame.
- err_timeout  out  1  sticky; drain timed out.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - State is IDLE.
  - All outputs are 0, including the sticky error flags.
  - All counters are 0.
- Output timing: all outputs are registered. cam_* to pipe_* latency is exactly 1 cycle.
- Forwarding rule: pipe_valid(t+1) = cam_valid(t) AND (pixel accepted at t). pipe_red/green/blue/visual take the accepted pixel; otherwise they hold their values with pipe_valid=0.
- States: IDLE, ARMED, STREAM, DRAIN, DONE.
- IDLE:
  - On start: go to ARMED.
  - Clear pixel_count, err_short and err_timeout.
- ARMED:
  - Pixels are discarded until cam_valid AND cam_sof.
  - That pixel is accepted: pixel_count=1, go to STREAM.
  - If NUM_PIXELS=1, the pixel also gets pipe_done and the state goes directly to DRAIN.
- STREAM:
  - Each cam_valid pixel is accepted and pixel_count increments.
  - The pixel that makes pixel_count==NUM_PIXELS is forwarded with pipe_done=1, then the state goes to DRAIN.
  - cam_valid gaps are allowed: no acceptance, no count.
- Short frame (cam_sof with cam_valid while in STREAM):
  - Set err_short.
  - pixel_count restarts at 1 with this pixel.
  - pipe_done is not asserted for the truncated frame.
- DRAIN:
  - No pixels are accepted; pipe_valid=0.
  - A drain counter runs from 0.
  - ret_done=1: go to DONE.
  - Drain counter reaches DRAIN_TIMEOUT-1 without ret_done: set err_timeout and go to DONE.
- DONE (one cycle):
  - Pulse frame_done for this cycle.
  - frame_count+1, wrapping modulo 2^FCNT_W.
  - continuous=1: go to ARMED with pixel_count=0. Otherwise go to IDLE.
- abort:
  - From any state, go to IDLE next cycle; pipe_valid=0 from that cycle.
  - No frame_done, frame_count unchanged, pipe_done never asserted.
- Simultaneous events:
  - abort together with start: abort wins.
  - start outside IDLE: ignored.
  - ret_done outside DRAIN: ignored.
- reset_n asserted mid-frame: everything clears immediately (asynchronous); data in flight in the pipeline is the pipeline's own concern.

Decomposition:
- Shared package hue_pkg:
  - State encoding enum hue_ctrl_state_t (IDLE=0, ARMED=1, STREAM=2, DRAIN=3, DONE=4).
  - Constants HUE_PIPE_LATENCY=6 and default NUM_PIXELS.
- Sub-module: hue_frame_counter, a pixel counter with load-1, increment and terminal-count flag, reused for the drain timer.

Test Plan (NUM_PIXELS=8, DRAIN_TIMEOUT=16 unless noted):
1. Reset, then start. Stream 3 non-SOF pixels, then SOF plus 8 continuous pixels (R=0..7); model ret_done 6 cycles after pipe_done. Required:
   - The 3 pre-SOF pixels are dropped.
   - pipe_valid is high for 8 cycles, starting 1 cycle after SOF.
   - pipe_done is high only with R=7.
   - frame_done pulses once; frame_count=1; busy falls the next cycle.
2. continuous=1, 3 back-to-back frames, with cam_valid toggled 1/0 every cycle. Required:
   - frame_count=3.
   - Exactly 24 pipe_valid cycles.
   - pixel_count never exceeds 8.
3. SOF again after 5 pixels of a frame. Required:
   - err_short=1 and pixel_count restarts at 1.
   - pipe_done arrives 8 accepted pixels after the second SOF.
4. ret_done held at 0 in DRAIN. Required:
   - err_timeout=1 after 16 cycles.
   - frame_done pulses; state goes to IDLE.
5. abort at pixel 4. Required:
   - pipe_valid=0 from the next cycle.
   - No frame_done, frame_count unchanged, busy=0.
   - A following start clears err_short and err_timeout.
6. reset_n pulsed low for 1 ns mid-STREAM, between clock edges. Required: all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/hue_pkg.sv
// Shared definitions for the RGB-to-hue front end: controller state encoding
// and pipeline constants.
package hue_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ARMED  = 3'd1,
      STREAM = 3'd2,
      DRAIN  = 3'd3,
      DONE   = 3'd4
   } hue_ctrl_state_t;

   localparam int HUE_PIPE_LATENCY = 6;
   localparam int HUE_NUM_PIXELS   = 307200;

endpackage

// File: rtl/hue_frame_ctrl_if.sv
// Pixel stream bundle around the frame controller: camera side in, hue
// pipeline side out, plus the done flag returned from the pipeline output.
interface hue_frame_ctrl_if;

   logic       cam_valid;
   logic       cam_sof;
   logic [7:0] cam_red;
   logic [7:0] cam_green;
   logic [7:0] cam_blue;
   logic       cam_visual;

   logic       pipe_valid;
   logic [7:0] pipe_red;
   logic [7:0] pipe_green;
   logic [7:0] pipe_blue;
   logic       pipe_visual;
   logic       pipe_done;

   logic       ret_done;

   // master is the controller; slave is the capture front end plus pipeline
   modport master (
      input  cam_valid, cam_sof, cam_red, cam_green, cam_blue, cam_visual, ret_done,
      output pipe_valid, pipe_red, pipe_green, pipe_blue, pipe_visual, pipe_done
   );

   modport slave (
      output cam_valid, cam_sof, cam_red, cam_green, cam_blue, cam_visual, ret_done,
      input  pipe_valid, pipe_red, pipe_green, pipe_blue, pipe_visual, pipe_done
   );

endinterface

// File: rtl/hue_frame_counter.sv
// Up-counter with clear, load-to-one and increment; last flags count == LAST.
// Used both as the frame pixel counter and as the drain timer.
module hue_frame_counter #(
   parameter int W    = 19,
   parameter int LAST = 1
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         clear,
   input  logic         load_one,
   input  logic         incr,
   output logic [W-1:0] count,
   output logic         last
);

   localparam logic [W-1:0] LAST_V = W'(LAST);

   logic [W-1:0] count_reg;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_reg <= '0;
      end else if (clear) begin
         count_reg <= '0;
      end else if (load_one) begin
         count_reg <= W'(1);
      end else if (incr) begin
         count_reg <= count_reg + W'(1);
      end
   end

   assign count = count_reg;
   assign last  = (count_reg == LAST_V);

endmodule

// File: rtl/hue_frame_ctrl.sv
// Frame sequencer gating the camera pixel stream into the hue pipeline:
// arms on start, aligns to SOF, counts pixels, drains and reports.
module hue_frame_ctrl
   import hue_pkg::*;
#(
   parameter int NUM_PIXELS    = HUE_NUM_PIXELS,
   parameter int CNT_W         = 19,
   parameter int DRAIN_TIMEOUT = 16,
   parameter int FCNT_W        = 16
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic              abort,
   input  logic              continuous,
   hue_frame_ctrl_if.master  px,
   output logic              busy,
   output logic              frame_done,
   output logic [FCNT_W-1:0] frame_count,
   output logic [CNT_W-1:0]  pixel_count,
   output logic              err_short,
   output logic              err_timeout
);

   localparam int DRAIN_W = (DRAIN_TIMEOUT > 2) ? $clog2(DRAIN_TIMEOUT) : 1;

   hue_ctrl_state_t state_reg, state_next;

   logic              accept;
   logic              pipe_done_next;
   logic              err_short_next, err_timeout_next;
   logic              frame_done_next;
   logic [FCNT_W-1:0] frame_count_next;
   logic              pix_clear, pix_load_one, pix_incr, pix_last;
   logic              drain_last;
   logic [DRAIN_W-1:0] drain_count;

   logic              pipe_valid_reg, pipe_done_reg, pipe_visual_reg;
   logic [7:0]        pipe_red_reg, pipe_green_reg, pipe_blue_reg;
   logic              busy_reg, frame_done_reg, err_short_reg, err_timeout_reg;
   logic [FCNT_W-1:0] frame_count_reg;

   // pix_last means the next accepted pixel completes the frame
   hue_frame_counter #(.W(CNT_W), .LAST(NUM_PIXELS - 1)) u_pixel_cnt (
      .clock    (clock),
      .reset_n  (reset_n),
      .clear    (pix_clear),
      .load_one (pix_load_one),
      .incr     (pix_incr),
      .count    (pixel_count),
      .last     (pix_last)
   );

   hue_frame_counter #(.W(DRAIN_W), .LAST(DRAIN_TIMEOUT - 1)) u_drain_cnt (
      .clock    (clock),
      .reset_n  (reset_n),
      .clear    (state_reg != DRAIN),
      .load_one (1'b0),
      .incr     (state_reg == DRAIN),
      .count    (drain_count),
      .last     (drain_last)
   );

   always_comb begin
      state_next       = state_reg;
      accept           = 1'b0;
      pipe_done_next   = 1'b0;
      pix_clear        = 1'b0;
      pix_load_one     = 1'b0;
      pix_incr         = 1'b0;
      err_short_next   = err_short_reg;
      err_timeout_next = err_timeout_reg;
      frame_done_next  = 1'b0;
      frame_count_next = frame_count_reg;

      if (abort) begin
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  state_next       = ARMED;
                  pix_clear        = 1'b1;
                  err_short_next   = 1'b0;
                  err_timeout_next = 1'b0;
               end
            end
            ARMED: begin
               if (px.cam_valid && px.cam_sof) begin
                  accept       = 1'b1;
                  pix_load_one = 1'b1;
                  if (NUM_PIXELS == 1) begin
                     pipe_done_next = 1'b1;
                     state_next     = DRAIN;
                  end else begin
                     state_next = STREAM;
                  end
               end
            end
            STREAM: begin
               if (px.cam_valid) begin
                  accept = 1'b1;
                  // an early SOF truncates the current frame and restarts counting
                  if (px.cam_sof) begin
                     err_short_next = 1'b1;
                     pix_load_one   = 1'b1;
                  end else begin
                     pix_incr = 1'b1;
                     if (pix_last) begin
                        pipe_done_next = 1'b1;
                        state_next     = DRAIN;
                     end
                  end
               end
            end
            DRAIN: begin
               if (px.ret_done || drain_last) begin
                  err_timeout_next = err_timeout_reg | ~px.ret_done;
                  state_next       = DONE;
                  frame_done_next  = 1'b1;
                  frame_count_next = frame_count_reg + FCNT_W'(1);
               end
            end
            DONE: begin
               if (continuous) begin
                  state_next = ARMED;
                  pix_clear  = 1'b1;
               end else begin
                  state_next = IDLE;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg       <= IDLE;
         pipe_valid_reg  <= 1'b0;
         pipe_done_reg   <= 1'b0;
         pipe_red_reg    <= '0;
         pipe_green_reg  <= '0;
         pipe_blue_reg   <= '0;
         pipe_visual_reg <= 1'b0;
         busy_reg        <= 1'b0;
         frame_done_reg  <= 1'b0;
         frame_count_reg <= '0;
         err_short_reg   <= 1'b0;
         err_timeout_reg <= 1'b0;
      end else begin
         state_reg       <= state_next;
         pipe_valid_reg  <= accept;
         pipe_done_reg   <= pipe_done_next;
         if (accept) begin
            pipe_red_reg    <= px.cam_red;
            pipe_green_reg  <= px.cam_green;
            pipe_blue_reg   <= px.cam_blue;
            pipe_visual_reg <= px.cam_visual;
         end
         busy_reg        <= (state_next != IDLE);
         frame_done_reg  <= frame_done_next;
         frame_count_reg <= frame_count_next;
         err_short_reg   <= err_short_next;
         err_timeout_reg <= err_timeout_next;
      end
   end

   assign px.pipe_valid  = pipe_valid_reg;
   assign px.pipe_done   = pipe_done_reg;
   assign px.pipe_red    = pipe_red_reg;
   assign px.pipe_green  = pipe_green_reg;
   assign px.pipe_blue   = pipe_blue_reg;
   assign px.pipe_visual = pipe_visual_reg;
   assign busy           = busy_reg;
   assign frame_done     = frame_done_reg;
   assign frame_count    = frame_count_reg;
   assign err_short      = err_short_reg;
   assign err_timeout    = err_timeout_reg;

endmodule

// File: tb/tb_hue_frame_ctrl.sv
// Self-checking bench for hue_frame_ctrl: per-cycle comparison against a
// behavioural frame model, directed scenarios plus randomized frames.
module tb_hue_frame_ctrl;

   localparam int NP = 8;
   localparam int CW = 4;
   localparam int DT = 16;
   localparam int FW = 16;

   localparam int P_IDLE = 0, P_ARMED = 1, P_STREAM = 2, P_DRAIN = 3, P_DONE = 4;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0, abort = 1'b0, continuous = 1'b0;
   logic          busy, frame_done, err_short, err_timeout;
   logic [FW-1:0] frame_count;
   logic [CW-1:0] pixel_count;

   hue_frame_ctrl_if px_if ();

   hue_frame_ctrl #(
      .NUM_PIXELS(NP), .CNT_W(CW), .DRAIN_TIMEOUT(DT), .FCNT_W(FW)
   ) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
      .continuous(continuous), .px(px_if), .busy(busy), .frame_done(frame_done),
      .frame_count(frame_count), .pixel_count(pixel_count),
      .err_short(err_short), .err_timeout(err_timeout)
   );

   always #5 clock = ~clock;

   // pipeline stand-in: returns pipe_done six cycles later when enabled
   logic [5:0] rd_line = '0;
   logic       ret_en = 1'b1;
   always @(negedge clock) rd_line <= {rd_line[4:0], px_if.pipe_done};
   assign px_if.ret_done = ret_en & rd_line[5];

   int n_checks = 0, n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc_n);
      end
   endtask

   // behavioural model of what the outputs must be
   int m_ph, m_pc, m_dr, m_fc;
   int m_pv, m_pd, m_fd, m_busy, m_es, m_et;
   int m_r, m_g, m_b, m_vis;
   int cyc_n = 0;

   task automatic model_reset();
      m_ph = P_IDLE; m_pc = 0; m_dr = 0; m_fc = 0;
      m_pv = 0; m_pd = 0; m_fd = 0; m_busy = 0; m_es = 0; m_et = 0;
      m_r = 0; m_g = 0; m_b = 0; m_vis = 0;
   endtask

   task automatic take();
      m_pv = 1; m_r = px_if.cam_red; m_g = px_if.cam_green;
      m_b = px_if.cam_blue; m_vis = px_if.cam_visual;
   endtask

   task automatic finish_frame(input int timed_out);
      m_ph = P_DONE; m_fd = 1; m_fc = (m_fc + 1) % (1 << FW);
      if (timed_out != 0) m_et = 1;
   endtask

   task automatic model_step();
      m_pv = 0; m_pd = 0; m_fd = 0;
      if (abort) m_ph = P_IDLE;
      else case (m_ph)
         P_IDLE: if (start) begin m_ph = P_ARMED; m_pc = 0; m_es = 0; m_et = 0; end
         P_ARMED, P_STREAM: begin
            if (px_if.cam_valid && (px_if.cam_sof || m_ph == P_STREAM)) begin
               take();
               if (px_if.cam_sof) begin
                  if (m_ph == P_STREAM) m_es = 1;
                  m_pc = 1;
               end else m_pc = m_pc + 1;
               m_ph = P_STREAM;
               if (m_pc == NP && !(px_if.cam_sof && NP > 1)) begin
                  m_pd = 1; m_ph = P_DRAIN; m_dr = 0;
               end
            end
         end
         P_DRAIN: begin
            if (px_if.ret_done) finish_frame(0);
            else if (m_dr == DT - 1) finish_frame(1);
            else m_dr = m_dr + 1;
         end
         default: begin
            if (continuous) begin m_ph = P_ARMED; m_pc = 0; end
            else m_ph = P_IDLE;
         end
      endcase
      m_busy = (m_ph != P_IDLE) ? 1 : 0;
   endtask

   // observation tallies for the directed scenarios
   int n_pv, n_pd, n_fd, pd_red, pd_idx, pd_cyc, pv_first, eto_cyc, prev_eto;
   task automatic clear_tallies();
      n_pv = 0; n_pd = 0; n_fd = 0; pd_red = -1; pd_idx = -1;
      pd_cyc = -1; pv_first = -1; eto_cyc = -1;
   endtask

   initial begin : compare
      model_reset();
      clear_tallies();
      prev_eto = 0;
      forever begin
         @(posedge clock or negedge reset_n);
         if (!reset_n) begin
            model_reset();
         end else begin
            model_step();
            #1;
            cyc_n++;
            check("pipe_valid",  32'(px_if.pipe_valid),  m_pv);
            check("pipe_done",   32'(px_if.pipe_done),   m_pd);
            check("pipe_red",    32'(px_if.pipe_red),    m_r);
            check("pipe_green",  32'(px_if.pipe_green),  m_g);
            check("pipe_blue",   32'(px_if.pipe_blue),   m_b);
            check("pipe_visual", 32'(px_if.pipe_visual), m_vis);
            check("busy",        32'(busy),        m_busy);
            check("frame_done",  32'(frame_done),  m_fd);
            check("frame_count", 32'(frame_count), m_fc);
            check("pixel_count", 32'(pixel_count), m_pc);
            check("err_short",   32'(err_short),   m_es);
            check("err_timeout", 32'(err_timeout), m_et);
            check("pcnt_bound",  32'(pixel_count <= CW'(NP)), 1);
            if (px_if.pipe_valid) begin
               n_pv++;
               if (n_pv == 1) pv_first = cyc_n;
            end
            if (px_if.pipe_done) begin
               n_pd++; pd_red = px_if.pipe_red; pd_idx = n_pv; pd_cyc = cyc_n;
            end
            if (frame_done) n_fd++;
            if (err_timeout && prev_eto == 0) eto_cyc = cyc_n;
            prev_eto = err_timeout;
         end
      end
   end

   task automatic cyc(input bit v, input bit sof, input logic [7:0] r,
                      input bit st = 1'b0, input bit ab = 1'b0);
      @(negedge clock);
      px_if.cam_valid  = v;
      px_if.cam_sof    = sof;
      px_if.cam_red    = r;
      px_if.cam_green  = 8'($urandom);
      px_if.cam_blue   = 8'($urandom);
      px_if.cam_visual = 1'($urandom);
      start = st;
      abort = ab;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'($urandom), 8'($urandom));
   endtask

   task automatic pixels(input int first, input int n, input bit gaps);
      for (int i = 0; i < n; i++) begin
         cyc(1'b1, 1'b0, 8'(first + i));
         if (gaps) cyc(1'b0, 1'b0, 8'($urandom));
      end
   endtask

   int sof_cyc, sent;
   bit v, s;

   initial begin : stim
      px_if.cam_valid = 0; px_if.cam_sof = 0; px_if.cam_red = 0;
      px_if.cam_green = 0; px_if.cam_blue = 0; px_if.cam_visual = 0;

      // reset state
      repeat (3) @(negedge clock);
      check("rst_busy", 32'(busy), 0);
      check("rst_pipe_valid", 32'(px_if.pipe_valid), 0);
      check("rst_frame_count", 32'(frame_count), 0);
      check("rst_pixel_count", 32'(pixel_count), 0);
      reset_n = 1'b1;
      idle(2);

      // 1: pre-SOF pixels dropped, one full frame
      clear_tallies();
      cyc(1'b0, 1'b0, 8'd0, 1'b1);
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'(200 + i));
      cyc(1'b1, 1'b1, 8'd0);
      sof_cyc = cyc_n;
      pixels(1, NP - 1, 1'b0);
      idle(12);
      check("t1_pv_cycles", n_pv, 8);
      check("t1_pv_latency", pv_first - sof_cyc, 1);
      check("t1_pd_count", n_pd, 1);
      check("t1_pd_red", pd_red, 7);
      check("t1_frame_done", n_fd, 1);
      check("t1_frame_count", 32'(frame_count), 1);
      check("t1_busy", 32'(busy), 0);

      // 2: continuous, three frames with alternating valid
      clear_tallies();
      continuous = 1'b1;
      cyc(1'b0, 1'b0, 8'd0, 1'b1);
      for (int f = 0; f < 3; f++) begin
         cyc(1'b1, 1'b1, 8'd0);
         cyc(1'b0, 1'b0, 8'($urandom));
         pixels(1, NP - 1, 1'b1);
         if (f == 2) continuous = 1'b0;
         idle(12);
      end
      check("t2_frame_count", 32'(frame_count), 4);
      check("t2_pv_cycles", n_pv, 24);
      check("t2_frame_done", n_fd, 3);
      check("t2_busy", 32'(busy), 0);

      // 3: SOF after five pixels
      clear_tallies();
      cyc(1'b0, 1'b0, 8'd0, 1'b1);
      cyc(1'b1, 1'b1, 8'd0);
      pixels(1, 4, 1'b0);
      cyc(1'b1, 1'b1, 8'd100);
      @(posedge clock); #2;
      check("t3_err_short", 32'(err_short), 1);
      check("t3_restart_count", 32'(pixel_count), 1);
      pixels(101, NP - 1, 1'b0);
      idle(12);
      check("t3_pd_after_8", pd_idx, 13);
      check("t3_pd_count", n_pd, 1);
      check("t3_frame_count", 32'(frame_count), 5);

      // 4: drain timeout (frame also carries a short SOF)
      clear_tallies();
      ret_en = 1'b0;
      cyc(1'b0, 1'b0, 8'd0, 1'b1);
      cyc(1'b1, 1'b1, 8'd0);
      pixels(1, 2, 1'b0);
      cyc(1'b1, 1'b1, 8'd50);
      pixels(51, NP - 1, 1'b0);
      idle(22);
      check("t4_timeout_delay", eto_cyc - pd_cyc, 16);
      check("t4_err_timeout", 32'(err_timeout), 1);
      check("t4_frame_done", n_fd, 1);
      check("t4_frame_count", 32'(frame_count), 6);
      check("t4_busy", 32'(busy), 0);
      ret_en = 1'b1;

      // 5: start clears errors; abort at the fourth pixel
      clear_tallies();
      cyc(1'b0, 1'b0, 8'd0, 1'b1);
      @(posedge clock); #2;
      check("t5_clr_err_short", 32'(err_short), 0);
      check("t5_clr_err_timeout", 32'(err_timeout), 0);
      cyc(1'b1, 1'b1, 8'd0);
      cyc(1'b1, 1'b1, 8'd1);
      cyc(1'b1, 1'b0, 8'd2);
      cyc(1'b1, 1'b0, 8'd3, 1'b0, 1'b1);
      @(posedge clock); #2;
      check("t5_abort_pv", 32'(px_if.pipe_valid), 0);
      check("t5_abort_busy", 32'(busy), 0);
      idle(4);
      check("t5_frame_done", n_fd, 0);
      check("t5_pd_count", n_pd, 0);
      check("t5_frame_count", 32'(frame_count), 6);
      check("t5_err_short", 32'(err_short), 1);
      cyc(1'b0, 1'b0, 8'd0, 1'b1);
      @(posedge clock); #2;
      check("t5_restart_clr", 32'(err_short), 0);
      cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
      idle(2);

      // 6: asynchronous reset mid-stream
      cyc(1'b0, 1'b0, 8'd0, 1'b1);
      cyc(1'b1, 1'b1, 8'd9);
      pixels(10, 3, 1'b0);
      @(posedge clock); #3;
      reset_n = 1'b0;
      #1;
      check("t6_pipe_valid", 32'(px_if.pipe_valid), 0);
      check("t6_pipe_red", 32'(px_if.pipe_red), 0);
      check("t6_busy", 32'(busy), 0);
      check("t6_frame_count", 32'(frame_count), 0);
      check("t6_pixel_count", 32'(pixel_count), 0);
      reset_n = 1'b1;
      idle(2);

      // randomized frames with gaps, junk, stray SOFs and ignored starts
      for (int f = 0; f < 8; f++) begin
         continuous = 1'($urandom_range(0, 1));
         cyc(1'b0, 1'b0, 8'($urandom), 1'b1);
         for (int j = 0; j < int'($urandom_range(0, 3)); j++)
            cyc(1'b1, 1'b0, 8'($urandom));
         sent = 0;
         while (sent < NP + 2) begin
            v = ($urandom_range(0, 2) != 0);
            s = v && (sent == 0 || $urandom_range(0, 15) == 0);
            cyc(v, s, 8'($urandom), 1'($urandom_range(0, 9) == 0));
            if (v) sent++;
         end
         continuous = 1'b0;
         idle(14);
         cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'($urandom_range(0, 1)));
         idle(2);
      end

      idle(3);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
